cacheline_burst_adaptor: RTL and testbench

CACHELINE_BURST_ADAPTOR -- requirements
Module: cacheline_burst_adaptor

---
 rtl/cacheline_burst_adaptor_if.sv | 26 ++
 rtl/cacheline_burst_adaptor.sv | 83 ++++++++
 tb/tb_cacheline_burst_adaptor.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_burst_adaptor_if.sv
// Cache-side line port and memory-side 64-bit burst port of the line/burst adaptor.
// slave is the adaptor's view; master is the view of whoever drives it.
interface cacheline_burst_adaptor_if;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Converts 256-bit cache line reads/writes into 4-beat 64-bit memory bursts.
// One beat moves per cycle with resp_i high; resp_o pulses once in DONE.
module cacheline_burst_adaptor (
  input  logic                        clk,
  input  logic                        rst,
  cacheline_burst_adaptor_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [1:0]   r_cnt;
  logic [31:0]  r_addr;
  logic [255:0] r_wline;
  logic [255:0] r_rline;
  logic [7:0]   w_off;
  logic         w_last;

  assign w_off  = {r_cnt, 6'd0};
  assign w_last = bus.resp_i && (r_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        // write has priority when both requests are up
        if (bus.write_i)     w_next = S_WRITE;
        else if (bus.read_i) w_next = S_READ;
      end
      S_READ:  if (w_last) w_next = S_DONE;
      S_WRITE: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 2'd0;
      r_addr  <= 32'd0;
      r_wline <= 256'd0;
      r_rline <= 256'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.write_i) begin
            r_wline <= bus.line_i;
            r_addr  <= bus.address_i & 32'hFFFF_FFE0;
            r_cnt   <= 2'd0;
          end else if (bus.read_i) begin
            r_addr  <= bus.address_i & 32'hFFFF_FFE0;
            r_cnt   <= 2'd0;
          end
        end
        S_READ: begin
          if (bus.resp_i) begin
            r_rline[w_off +: 64] <= bus.burst_i;
            r_cnt                <= r_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          if (bus.resp_i) r_cnt <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.read_o    = (r_state == S_READ);
    bus.write_o   = (r_state == S_WRITE);
    bus.resp_o    = (r_state == S_DONE);
    bus.address_o = r_addr;
    bus.line_o    = r_rline;
    bus.burst_o   = 64'd0;
    if (r_state == S_WRITE) bus.burst_o = r_wline[w_off +: 64];
  end
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Random and directed line read/write traffic against a cycle-level model; a
// negedge monitor pops per-cycle and per-transaction expectations and compares.
module tb_cacheline_burst_adaptor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  cacheline_burst_adaptor_if bus();
  cacheline_burst_adaptor dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    bit           rd;
    bit           wr;
    bit           rsp;
    bit           chk_line;
    logic [63:0]  bo;
    logic [31:0]  ad;
    logic [255:0] ln;
  } ce_t;

  typedef struct {
    bit           wr;
    logic [31:0]  ad;
    logic [255:0] ln;
  } re_t;

  ce_t          cyc_q[$];
  re_t          resp_q[$];
  logic [255:0] mdl_line = '0;
  logic [31:0]  mdl_addr = '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic push_ce(input bit rd, input bit wr, input bit rsp, input bit cl, input logic [63:0] bo);
    cyc_q.push_back('{cyc, rd, wr, rsp, cl, bo, mdl_addr, mdl_line});
  endtask

  task automatic garbage();
    bus.burst_i   = rand64();
    bus.address_i = $urandom;
    bus.line_i    = rand256();
  endtask

  always @(negedge clk) begin
    ce_t e;
    re_t r;
    if (!rst) begin
      if (cyc_q.size() != 0 && cyc_q[0].cyc == cyc) begin
        e = cyc_q.pop_front();
        chk("read_o",    256'(bus.read_o),    256'(e.rd));
        chk("write_o",   256'(bus.write_o),   256'(e.wr));
        chk("resp_o",    256'(bus.resp_o),    256'(e.rsp));
        chk("burst_o",   256'(bus.burst_o),   256'(e.bo));
        chk("address_o", 256'(bus.address_o), 256'(e.ad));
        if (e.chk_line) chk("line_o", bus.line_o, e.ln);
      end
      if (bus.resp_o) begin
        if (resp_q.size() == 0) chk("resp_o_unexpected", 256'(bus.resp_o), 256'(0));
        else begin
          r = resp_q.pop_front();
          chk("address_o_at_resp", 256'(bus.address_o), 256'(r.ad));
          if (!r.wr) chk("line_o_at_resp", bus.line_o, r.ln);
        end
      end
    end
  end

  // Entered and left just after a rising edge. abort_after>=0 resets the DUT
  // once that many beats have been acknowledged, leaving the request asserted.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [255:0] line,
                     input logic [3:0][63:0] beats, input logic [3:0][1:0] st,
                     input int abort_after, input bit hold);
    bit is_wr;
    is_wr         = wr;
    bus.read_i    = rd;
    bus.write_i   = wr;
    bus.address_i = addr;
    bus.line_i    = line;
    bus.resp_i    = 1'($urandom_range(0, 1));
    bus.burst_i   = rand64();
    push_ce(0, 0, 0, 1, 64'd0);
    if (abort_after < 0)
      resp_q.push_back('{is_wr, addr & 32'hFFFF_FFE0, {beats[3], beats[2], beats[1], beats[0]}});
    mdl_addr = addr & 32'hFFFF_FFE0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (k == abort_after) begin
        bus.resp_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_read_o",    256'(bus.read_o),    256'(0));
        chk("rst_write_o",   256'(bus.write_o),   256'(0));
        chk("rst_resp_o",    256'(bus.resp_o),    256'(0));
        chk("rst_burst_o",   256'(bus.burst_o),   256'(0));
        chk("rst_address_o", 256'(bus.address_o), 256'(0));
        chk("rst_line_o",    bus.line_o,          256'(0));
        mdl_line = '0;
        mdl_addr = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      for (int s = 0; s < int'(st[k]); s++) begin
        bus.resp_i = 1'b0;
        garbage();
        push_ce(!is_wr, is_wr, 0, !(!is_wr && k > 0), is_wr ? line[64*k +: 64] : 64'd0);
        @(posedge clk); #1;
      end
      garbage();
      bus.resp_i  = 1'b1;
      bus.burst_i = beats[k];
      push_ce(!is_wr, is_wr, 0, !(!is_wr && k > 0), is_wr ? line[64*k +: 64] : 64'd0);
      @(posedge clk); #1;
    end
    if (!is_wr) mdl_line = {beats[3], beats[2], beats[1], beats[0]};
    garbage();
    bus.resp_i = 1'b1;
    if (!hold) begin
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
    end
    push_ce(0, 0, 1, 1, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      bus.resp_i  = 1'($urandom_range(0, 1));
      garbage();
      push_ce(0, 0, 0, 1, 64'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][63:0] bt;
    logic [3:0][1:0]  st;
    logic [255:0]     ln;
    logic [31:0]      ad;
    bit               rd, wr, hold;
    bus.read_i = 0; bus.write_i = 0; bus.resp_i = 0;
    bus.burst_i = '0; bus.address_i = '0; bus.line_i = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset_read_o",    256'(bus.read_o),    256'(0));
    chk("reset_write_o",   256'(bus.write_o),   256'(0));
    chk("reset_resp_o",    256'(bus.resp_o),    256'(0));
    chk("reset_burst_o",   256'(bus.burst_o),   256'(0));
    chk("reset_address_o", 256'(bus.address_o), 256'(0));
    chk("reset_line_o",    bus.line_o,          256'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // plain read, no stalls
    bt = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    txn(1, 0, 32'h1234_5678, rand256(), bt, '0, -1, 0);
    chk("read_addr_aligned", 256'(bus.address_o), 256'(32'h1234_5660));
    chk("read_line", bus.line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    idle(1);

    // write, ack pattern 1,0,0,1,1,0,1
    ln = 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
    txn(0, 1, 32'h8000_003f, ln, '0, {2'd1, 2'd0, 2'd2, 2'd0}, -1, 0);
    idle(1);

    // simultaneous read and write: write wins
    txn(1, 1, 32'hdead_beef, rand256(), '0, {2'd0, 2'd1, 2'd0, 2'd0}, -1, 0);
    idle(1);

    // reset after two read beats, request held, then restart from beat 0
    bt = {rand64(), rand64(), rand64(), rand64()};
    txn(1, 0, 32'h0000_1040, rand256(), bt, '0, 2, 1);
    bt = {rand64(), rand64(), rand64(), rand64()};
    txn(1, 0, 32'h0000_1040, rand256(), bt, {2'd0, 2'd1, 2'd0, 2'd1}, -1, 0);
    idle(1);

    // back-to-back reads with request held through DONE
    bt = {rand64(), rand64(), rand64(), rand64()};
    txn(1, 0, 32'h5555_0000, rand256(), bt, '0, -1, 1);
    bt = {rand64(), rand64(), rand64(), rand64()};
    txn(1, 0, 32'h6666_0020, rand256(), bt, {2'd0, 2'd0, 2'd0, 2'd2}, -1, 0);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      rd   = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      hold = 1'($urandom_range(0, 1));
      ad   = $urandom;
      ln   = rand256();
      bt   = {rand64(), rand64(), rand64(), rand64()};
      st   = 8'($urandom_range(0, 255));
      txn(rd, wr, ad, ln, bt, st, -1, hold);
      if (!hold || i == 39) idle($urandom_range(1, 3));
    end

    idle(2);
    chk("cycle_queue_drained", 256'(cyc_q.size()),  256'(0));
    chk("resp_queue_drained",  256'(resp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
